// File: rtl/salsa20_inv_dround_iter.sv
// Iterative inverse Salsa20 double round: one inverse half-round (row, then column) per cycle.
// Optional SALSA20_INV_SELFCHECK_EN re-applies double_round after each round and flags mismatches on chk_err.

`ifdef SALSA20_INV_SELFCHECK_EN
module double_round (
  input  logic [511:0] i_x,
  output logic [511:0] o_y
);
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Diagonal word a leads each group; col selects column vs row neighbours.
  function automatic logic [511:0] fwd_half(input logic [511:0] s, input logic col);
    logic [31:0]  w [16];
    logic [3:0]   a, b, c, d;
    logic [511:0] r;
    for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
    for (int g = 0; g < 4; g++) begin
      a = 4'(5 * g);
      if (col) begin
        b = a + 4'd4; c = a + 4'd8; d = a + 4'd12;
      end else begin
        b = (a & 4'hC) | ((a + 4'd1) & 4'h3);
        c = (a & 4'hC) | ((a + 4'd2) & 4'h3);
        d = (a & 4'hC) | ((a + 4'd3) & 4'h3);
      end
      w[b] = w[b] ^ rotl(w[a] + w[d], 7);
      w[c] = w[c] ^ rotl(w[b] + w[a], 9);
      w[d] = w[d] ^ rotl(w[c] + w[b], 13);
      w[a] = w[a] ^ rotl(w[d] + w[c], 18);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  assign o_y = fwd_half(fwd_half(i_x, 1'b1), 1'b0);
endmodule
`endif

module salsa20_inv_dround_iter #(
  parameter int DR_COUNT = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] d_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] d_out,
`ifdef SALSA20_INV_SELFCHECK_EN
  output logic         chk_err,
`endif
  output logic         busy
);
  typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_DONE} state_t;

  localparam logic [7:0] LAST = 8'(DR_COUNT - 1);

  state_t       r_state, w_next;
  logic [511:0] r_data, w_half;
  logic [7:0]   r_cnt;
  logic         w_accept, w_last;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Undoes the quarter-round steps in reverse order; group layout mirrors the forward round.
  function automatic logic [511:0] inv_half(input logic [511:0] s, input logic col);
    logic [31:0]  w [16];
    logic [3:0]   a, b, c, d;
    logic [511:0] r;
    for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
    for (int g = 0; g < 4; g++) begin
      a = 4'(5 * g);
      if (col) begin
        b = a + 4'd4; c = a + 4'd8; d = a + 4'd12;
      end else begin
        b = (a & 4'hC) | ((a + 4'd1) & 4'h3);
        c = (a & 4'hC) | ((a + 4'd2) & 4'h3);
        d = (a & 4'hC) | ((a + 4'd3) & 4'h3);
      end
      w[a] = w[a] ^ rotl(w[d] + w[c], 18);
      w[d] = w[d] ^ rotl(w[c] + w[b], 13);
      w[c] = w[c] ^ rotl(w[b] + w[a], 9);
      w[b] = w[b] ^ rotl(w[a] + w[d], 7);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  assign w_half   = inv_half(r_data, r_state == S_COL);
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST);
  assign d_out    = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ROW;
      end
      S_ROW: begin
        busy   = 1'b1;
        w_next = S_COL;
      end
      S_COL: begin
        busy   = 1'b1;
        w_next = w_last ? S_DONE : S_ROW;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_data <= d_in;
      r_cnt  <= '0;
    end else if (r_state == S_ROW || r_state == S_COL) begin
      r_data <= w_half;
      if (r_state == S_COL && !w_last) r_cnt <= r_cnt + 8'd1;
    end
  end

`ifdef SALSA20_INV_SELFCHECK_EN
  logic [511:0] r_shadow, w_fwd;
  logic         r_chk_err;

  double_round u_fwd (.i_x(w_half), .o_y(w_fwd));

  // Shadow holds the state at the start of the current inverse double round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_chk_err <= 1'b0;
    end else if (w_accept) begin
      r_shadow  <= d_in;
      r_chk_err <= 1'b0;
    end else if (r_state == S_COL) begin
      if (w_fwd != r_shadow) r_chk_err <= 1'b1;
      r_shadow <= w_half;
    end
  end

  assign chk_err = r_chk_err;
`endif
endmodule

// File: tb/tb_salsa20_inv_dround_iter.sv
// Self-checking bench: two instances (DR_COUNT=1 and 10) checked against a word-level Salsa20 model.
module tb_salsa20_inv_dround_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   iv, orr;
  logic [1:0]   ir, ov, bsy;
  logic [511:0] din [2];
  logic [511:0] dout0, dout1;
`ifdef SALSA20_INV_SELFCHECK_EN
  logic [1:0]   chk;
`endif

  int n_chk = 0;
  int n_fail = 0;

  salsa20_inv_dround_iter #(.DR_COUNT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .d_in(din[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .d_out(dout0),
`ifdef SALSA20_INV_SELFCHECK_EN
    .chk_err(chk[0]),
`endif
    .busy(bsy[0]));

  salsa20_inv_dround_iter #(.DR_COUNT(10)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .d_in(din[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .d_out(dout1),
`ifdef SALSA20_INV_SELFCHECK_EN
    .chk_err(chk[1]),
`endif
    .busy(bsy[1]));

  localparam int RG [4][4] = '{'{0, 1, 2, 3}, '{5, 6, 7, 4}, '{10, 11, 8, 9}, '{15, 12, 13, 14}};
  localparam int CG [4][4] = '{'{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11}};

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Inverse: n times (inverse rowround, then inverse columnround).
  function automatic logic [511:0] m_inv(input logic [511:0] s, input int n);
    logic [31:0] w [16];
    logic [31:0] z0, z1, z2, z3, y0, y1, y2, y3;
    int idx [4];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
    for (int k = 0; k < n; k++)
      for (int p = 0; p < 2; p++)
        for (int g = 0; g < 4; g++) begin
          for (int j = 0; j < 4; j++) idx[j] = (p == 0) ? RG[g][j] : CG[g][j];
          z0 = w[idx[0]]; z1 = w[idx[1]]; z2 = w[idx[2]]; z3 = w[idx[3]];
          y0 = z0 ^ rl(z3 + z2, 18);
          y3 = z3 ^ rl(z2 + z1, 13);
          y2 = z2 ^ rl(z1 + y0, 9);
          y1 = z1 ^ rl(y0 + y3, 7);
          w[idx[0]] = y0; w[idx[1]] = y1; w[idx[2]] = y2; w[idx[3]] = y3;
        end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  // Forward double_round applied n times: columnround, then rowround.
  function automatic logic [511:0] m_fwd(input logic [511:0] s, input int n);
    logic [31:0] w [16];
    logic [31:0] y0, y1, y2, y3, z0, z1, z2, z3;
    int idx [4];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
    for (int k = 0; k < n; k++)
      for (int p = 0; p < 2; p++)
        for (int g = 0; g < 4; g++) begin
          for (int j = 0; j < 4; j++) idx[j] = (p == 0) ? CG[g][j] : RG[g][j];
          y0 = w[idx[0]]; y1 = w[idx[1]]; y2 = w[idx[2]]; y3 = w[idx[3]];
          z1 = y1 ^ rl(y0 + y3, 7);
          z2 = y2 ^ rl(z1 + y0, 9);
          z3 = y3 ^ rl(z2 + z1, 13);
          z0 = y0 ^ rl(z3 + z2, 18);
          w[idx[0]] = z0; w[idx[1]] = z1; w[idx[2]] = z2; w[idx[3]] = z3;
        end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_state();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] get_dout(input int w);
    return (w == 1) ? dout1 : dout0;
  endfunction

  function automatic int dr_of(input int w);
    return (w == 1) ? 10 : 1;
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input int w, input logic [511:0] d);
    @(negedge clk);
    iv[w] = 1'b1;
    din[w] = d;
    @(negedge clk);
    iv[w] = 1'b0;
  endtask

  // Counts rising edges after the accepting edge until out_valid; bounded.
  task automatic wait_done(input int w, output int lat);
    lat = 0;
    while (!ov[w] && lat < 1000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic retire(input int w);
    orr[w] = 1'b1;
    @(negedge clk);
    orr[w] = 1'b0;
    check("retire_out_valid", 512'(ov[w]), '0);
    check("retire_in_ready", 512'(ir[w]), 512'(1));
    check("retire_busy", 512'(bsy[w]), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] d, orig, kv, hold;
    int lat;
    logic [31:0] kw [16];

    iv = '0; orr = '0; din[0] = '0; din[1] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check("rst_in_ready", 512'(ir[w]), 512'(1));
      check("rst_out_valid", 512'(ov[w]), '0);
      check("rst_busy", 512'(bsy[w]), '0);
      check("rst_d_out", get_dout(w), '0);
    end

    start(0, '0);
    wait_done(0, lat);
    check("zero_latency", 512'(lat), 512'(2));
    check("zero_d_out", dout0, '0);
    retire(0);

    kw = '{32'h8186a22d, 32'h0040a284, 32'h82479210, 32'h06929051,
           32'h08000090, 32'h02402200, 32'h00004000, 32'h00800000,
           32'h00010200, 32'h20400000, 32'h08008104, 32'h00000000,
           32'h20500000, 32'ha0000040, 32'h0008180a, 32'h612a8020};
    for (int i = 0; i < 16; i++) kv[32*i +: 32] = kw[i];
    start(0, kv);
    wait_done(0, lat);
    check("kv_latency", 512'(lat), 512'(2));
    check("kv_d_out", dout0, 512'(1));
    retire(0);

    orig = '0;
    orig[31:0] = 32'hdeadbeef;
    orig[8*32 +: 32] = 32'hfeedface;
    start(1, m_fwd(orig, 10));
    check("rt_busy", 512'(bsy[1]), 512'(1));
    check("rt_in_ready", 512'(ir[1]), '0);
    wait_done(1, lat);
    check("rt_latency", 512'(lat), 512'(20));
    check("rt_d_out", dout1, orig);
`ifdef SALSA20_INV_SELFCHECK_EN
    check("rt_chk_err", 512'(chk[1]), '0);
`endif

    hold = dout1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin iv[1] = 1'b1; din[1] = rand_state(); end
      if (i == 3) iv[1] = 1'b0;
      @(negedge clk);
      check("bp_d_out_stable", dout1, hold);
      check("bp_out_valid", 512'(ov[1]), 512'(1));
      check("bp_in_ready", 512'(ir[1]), '0);
    end
    retire(1);
    @(negedge clk);
    check("bp_pulse_ignored", 512'(bsy[1]), '0);

    start(1, rand_state());
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 512'(bsy[1]), '0);
    check("mid_rst_out_valid", 512'(ov[1]), '0);
    check("mid_rst_d_out", dout1, '0);
    @(negedge clk);
    rst = 1'b0;
    d = rand_state();
    start(1, d);
    wait_done(1, lat);
    check("post_rst_latency", 512'(lat), 512'(20));
    check("post_rst_d_out", dout1, m_inv(d, 10));
    retire(1);

    for (int k = 0; k < 8; k++) begin
      int w;
      w = k % 2;
      d = rand_state();
      start(w, d);
      wait_done(w, lat);
      check("rand_latency", 512'(lat), 512'(2 * dr_of(w)));
      check("rand_d_out", get_dout(w), m_inv(d, dr_of(w)));
      check("rand_roundtrip", m_fwd(get_dout(w), dr_of(w)), d);
      repeat ($urandom_range(0, 3)) begin
        hold = get_dout(w);
        @(negedge clk);
        check("rand_stall_stable", get_dout(w), hold);
      end
      retire(w);
    end

`ifdef SALSA20_INV_SELFCHECK_EN
    check("final_chk_err0", 512'(chk[0]), '0);
    check("final_chk_err1", 512'(chk[1]), '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
